// File: rtl/la_capture.sv
// la_capture: trigger-qualified circular capture buffer for the muxed
// logic-analyzer word. Once armed it records every cycle, keeping pre-trigger
// history in a ring. It stops a programmed number of samples after a masked
// compare hit. Reads index the captured window oldest-first.
module la_capture #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] la_dat_in,
  input  logic             arm,
  input  logic             abort,
  input  logic [WIDTH-1:0] trig_mask,
  input  logic [WIDTH-1:0] trig_value,
  input  logic [AW:0]      post_len,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             triggered,
  output logic             done,
  output logic [AW:0]      fill_cnt,
  output logic [AW-1:0]    trig_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE_C = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      fill_cnt_q, fill_cnt_d;
  logic [AW-1:0]    trig_addr_q, trig_addr_d;
  logic [AW:0]      rem_q, rem_d;
  logic [AW:0]      post_len_q, post_len_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             triggered_q, triggered_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AW-1:0]    trig_idx_q, trig_idx_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  logic             match_s;
  logic [AW:0]      plen_clamp_s;
  logic [AW:0]      fill_inc_s;
  logic [AW-1:0]    rd_start_s;
  logic [AW-1:0]    rd_idx_s;
  logic             rd_accept_s;
  logic             wr_en_s;
  logic [AW-1:0]    start_d_s;

  // Helper terms: trigger compare, clamped post length, saturating fill and read addressing
  always_comb begin
    match_s = (((la_dat_in ^ value_q) & mask_q) == {WIDTH{1'b0}});
    if (post_len == {(AW+1){1'b0}}) begin
      plen_clamp_s = ONE_C;
    end else if (post_len > DEPTH_C) begin
      plen_clamp_s = DEPTH_C;
    end else begin
      plen_clamp_s = post_len;
    end
    if (fill_cnt_q == DEPTH_C) begin
      fill_inc_s = fill_cnt_q;
      rd_start_s = wr_ptr_q;
    end else begin
      fill_inc_s = fill_cnt_q + ONE_C;
      rd_start_s = {AW{1'b0}};
    end
    rd_idx_s    = rd_start_s + rd_addr;
    rd_accept_s = rd_req && (state_q == ST_DONE);
  end

  // Capture FSM next state and bookkeeping; abort overrides everything, including arm
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    trig_addr_d = trig_addr_q;
    rem_d       = rem_q;
    post_len_d  = post_len_q;
    mask_d      = mask_q;
    value_d     = value_q;
    triggered_d = triggered_q;
    wr_en_s     = 1'b0;
    if (abort) begin
      state_d     = ST_IDLE;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_d     = ST_PRE;
            wr_ptr_d    = {AW{1'b0}};
            fill_cnt_d  = {(AW+1){1'b0}};
            trig_addr_d = {AW{1'b0}};
            rem_d       = {(AW+1){1'b0}};
            triggered_d = 1'b0;
            post_len_d  = plen_clamp_s;
            mask_d      = trig_mask;
            value_d     = trig_value;
          end else begin
            state_d = state_q;
          end
        end
        ST_PRE: begin
          wr_en_s    = 1'b1;
          wr_ptr_d   = wr_ptr_q + PTR_ONE_C;
          fill_cnt_d = fill_inc_s;
          if (match_s) begin
            trig_addr_d = wr_ptr_q;
            triggered_d = 1'b1;
            rem_d       = post_len_q - ONE_C;
            if (post_len_q == ONE_C) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_POST;
            end
          end else begin
            state_d = ST_PRE;
          end
        end
        ST_POST: begin
          wr_en_s    = 1'b1;
          wr_ptr_d   = wr_ptr_q + PTR_ONE_C;
          fill_cnt_d = fill_inc_s;
          rem_d      = rem_q - ONE_C;
          if (rem_q == ONE_C) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_POST;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Registered status outputs, trigger index of the finished window, and read port
  always_comb begin
    busy_d = (state_d == ST_PRE) || (state_d == ST_POST);
    done_d = (state_d == ST_DONE);
    if (fill_cnt_d == DEPTH_C) begin
      start_d_s = wr_ptr_d;
    end else begin
      start_d_s = {AW{1'b0}};
    end
    if (state_d == ST_DONE) begin
      trig_idx_d = trig_addr_d - start_d_s;
    end else begin
      trig_idx_d = {AW{1'b0}};
    end
    rd_valid_d = rd_accept_s;
    if (rd_accept_s) begin
      if ({1'b0, rd_addr} >= fill_cnt_q) begin
        rd_data_d = {WIDTH{1'b0}};
      end else begin
        rd_data_d = mem[rd_idx_s];
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= {AW{1'b0}};
      fill_cnt_q  <= {(AW+1){1'b0}};
      trig_addr_q <= {AW{1'b0}};
      rem_q       <= {(AW+1){1'b0}};
      post_len_q  <= {(AW+1){1'b0}};
      mask_q      <= {WIDTH{1'b0}};
      value_q     <= {WIDTH{1'b0}};
      triggered_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trig_idx_q  <= {AW{1'b0}};
      rd_valid_q  <= 1'b0;
      rd_data_q   <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      trig_addr_q <= trig_addr_d;
      rem_q       <= rem_d;
      post_len_q  <= post_len_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
      triggered_q <= triggered_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      trig_idx_q  <= trig_idx_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Sample RAM write port; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem[wr_ptr_q] <= la_dat_in;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign fill_cnt  = fill_cnt_q;
  assign trig_idx  = trig_idx_q;

endmodule

// File: tb/tb_la_capture.sv
// Self-checking bench for la_capture with a window-level reference model.
module tb_la_capture;
  localparam int WIDTH = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clk = 1'b0;
  logic             rst, arm, abort, rd_req;
  logic [WIDTH-1:0] la_dat_in, trig_mask, trig_value, rd_data;
  logic [AW:0]      post_len, fill_cnt;
  logic [AW-1:0]    rd_addr, trig_idx;
  logic             rd_valid, busy, triggered, done;

  logic [31:0] stim [0:511];
  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  la_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .la_dat_in(la_dat_in), .arm(arm), .abort(abort),
    .trig_mask(trig_mask), .trig_value(trig_value), .post_len(post_len),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .triggered(triggered), .done(done), .fill_cnt(fill_cnt),
    .trig_idx(trig_idx)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (window arithmetic over the sample list)
  function automatic int eff_post(input int plen);
    if (plen == 0) return 1;
    if (plen > DEPTH) return DEPTH;
    return plen;
  endfunction

  function automatic int model_trig(input logic [31:0] m, input logic [31:0] v);
    for (int i = 0; i < 512; i++)
      if (((stim[i] ^ v) & m) == 32'h0) return i;
    return -1;
  endfunction

  function automatic int model_fill(input int total);
    return (total < DEPTH) ? total : DEPTH;
  endfunction

  function automatic int model_tidx(input int trig, input int total);
    return trig - (total - model_fill(total));
  endfunction

  function automatic logic [31:0] model_rd(input int total, input int idx);
    int f;
    f = model_fill(total);
    if (idx >= f) return 32'h0;
    return stim[total - f + idx];
  endfunction

  // ---------------- stimulus tasks
  task automatic arm_capture(input logic [31:0] m, input logic [31:0] v, input int plen);
    trig_mask  = m;
    trig_value = v;
    post_len   = 7'(plen);
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
  endtask

  task automatic run_samples(input int rearm_at, output int done_at);
    done_at = -1;
    for (int i = 0; i < 400; i++) begin
      la_dat_in = stim[i];
      if (i == rearm_at) begin
        arm       = 1'b1;
        trig_mask = 32'h0;
        post_len  = 7'd2;
      end
      tick();
      arm = 1'b0;
      if (done === 1'b1) begin
        done_at = i + 1;
        break;
      end
    end
  endtask

  task automatic do_read(input int a, output logic [31:0] d, output logic v);
    rd_req  = 1'b1;
    rd_addr = 6'(a);
    tick();
    rd_req  = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 512; i++) stim[i] = 32'(i);
  endtask

  // ---------------- tests
  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; abort = 1'b0; rd_req = 1'b0; rd_addr = 6'd0;
    la_dat_in = 32'h0; trig_mask = 32'h0; trig_value = 32'h0; post_len = 7'd0;
    tick(); tick();
    total_cnt++; if ({busy, done, triggered, rd_valid} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {busy, done, triggered, rd_valid}); else pass_cnt++;
    total_cnt++; if (fill_cnt !== 7'd0 || trig_idx !== 6'd0) $display("FAIL reset_counts fill=%0d tidx=%0d want 0/0", fill_cnt, trig_idx); else pass_cnt++;
    total_cnt++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data got %h want 0", rd_data); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int da, tot; logic [31:0] d; logic v;
    for (int i = 0; i < 512; i++) stim[i] = 32'h10 + 32'(i);
    tot = model_trig(32'h0, 32'h0) + eff_post(4);
    arm_capture(32'h0, 32'h0, 4);
    run_samples(-1, da);
    total_cnt++; if (da !== tot) $display("FAIL basic_latency got %0d want %0d", da, tot); else pass_cnt++;
    total_cnt++; if (fill_cnt !== 7'(model_fill(tot))) $display("FAIL basic_fill got %0d want %0d", fill_cnt, model_fill(tot)); else pass_cnt++;
    total_cnt++; if (trig_idx !== 6'(model_tidx(0, tot)) || triggered !== 1'b1 || busy !== 1'b0) $display("FAIL basic_status tidx=%0d trg=%b busy=%b want 0/1/0", trig_idx, triggered, busy); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      do_read(i, d, v);
      total_cnt++; if (v !== 1'b1 || d !== model_rd(tot, i)) $display("FAIL basic_read[%0d] got %h v=%b want %h", i, d, v, model_rd(tot, i)); else pass_cnt++;
    end
  endtask

  task automatic test_trig_mid(input int rearm_at);
    int da, tot, tg; logic [31:0] d; logic v;
    fill_ramp();
    tg  = model_trig(32'hFF, 32'h2A);
    tot = tg + eff_post(8);
    arm_capture(32'hFF, 32'h2A, 8);
    run_samples(rearm_at, da);
    total_cnt++; if (da !== tot) $display("FAIL mid_latency(rearm=%0d) got %0d want %0d", rearm_at, da, tot); else pass_cnt++;
    total_cnt++; if (fill_cnt !== 7'(model_fill(tot))) $display("FAIL mid_fill got %0d want %0d", fill_cnt, model_fill(tot)); else pass_cnt++;
    total_cnt++; if (trig_idx !== 6'(model_tidx(tg, tot))) $display("FAIL mid_tidx got %0d want %0d", trig_idx, model_tidx(tg, tot)); else pass_cnt++;
    do_read(0, d, v);
    total_cnt++; if (v !== 1'b1 || d !== model_rd(tot, 0)) $display("FAIL mid_read0 got %h want %h", d, model_rd(tot, 0)); else pass_cnt++;
    do_read(49, d, v);
    total_cnt++; if (v !== 1'b1 || d !== model_rd(tot, 49)) $display("FAIL mid_read49 got %h want %h", d, model_rd(tot, 49)); else pass_cnt++;
    do_read(50, d, v);
    total_cnt++; if (v !== 1'b1 || d !== 32'h0) $display("FAIL mid_read50 got %h want 0", d); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int da, tot, tg; logic [31:0] d; logic v;
    fill_ramp();
    tg  = model_trig(32'hFF, 32'h64);
    tot = tg + eff_post(8);
    arm_capture(32'hFF, 32'h64, 8);
    run_samples(-1, da);
    total_cnt++; if (da !== tot) $display("FAIL wrap_latency got %0d want %0d", da, tot); else pass_cnt++;
    total_cnt++; if (fill_cnt !== 7'(model_fill(tot))) $display("FAIL wrap_fill got %0d want %0d", fill_cnt, model_fill(tot)); else pass_cnt++;
    total_cnt++; if (trig_idx !== 6'(model_tidx(tg, tot))) $display("FAIL wrap_tidx got %0d want %0d", trig_idx, model_tidx(tg, tot)); else pass_cnt++;
    do_read(0, d, v);
    total_cnt++; if (d !== model_rd(tot, 0)) $display("FAIL wrap_read0 got %h want %h", d, model_rd(tot, 0)); else pass_cnt++;
    do_read(63, d, v);
    total_cnt++; if (d !== model_rd(tot, 63)) $display("FAIL wrap_read63 got %h want %h", d, model_rd(tot, 63)); else pass_cnt++;
  endtask

  task automatic test_post_len_bounds();
    int da, tot, tg; logic [31:0] d; logic v;
    fill_ramp();
    tg  = model_trig(32'hFF, 32'h05);
    tot = tg + eff_post(0);
    arm_capture(32'hFF, 32'h05, 0);
    run_samples(-1, da);
    total_cnt++; if (da !== tot) $display("FAIL plen0_latency got %0d want %0d", da, tot); else pass_cnt++;
    total_cnt++; if (trig_idx !== 6'(model_tidx(tg, tot)) || fill_cnt !== 7'(model_fill(tot))) $display("FAIL plen0_idx tidx=%0d fill=%0d want %0d/%0d", trig_idx, fill_cnt, model_tidx(tg, tot), model_fill(tot)); else pass_cnt++;
    tg  = model_trig(32'hFF, 32'h0A);
    tot = tg + eff_post(100);
    arm_capture(32'hFF, 32'h0A, 100);
    run_samples(-1, da);
    total_cnt++; if (da !== tot) $display("FAIL plen100_latency got %0d want %0d", da, tot); else pass_cnt++;
    total_cnt++; if (trig_idx !== 6'(model_tidx(tg, tot)) || fill_cnt !== 7'(model_fill(tot))) $display("FAIL plen100_idx tidx=%0d fill=%0d want %0d/%0d", trig_idx, fill_cnt, model_tidx(tg, tot), model_fill(tot)); else pass_cnt++;
    do_read(0, d, v);
    total_cnt++; if (d !== model_rd(tot, 0)) $display("FAIL plen100_read0 got %h want %h", d, model_rd(tot, 0)); else pass_cnt++;
  endtask

  task automatic test_abort();
    fill_ramp();
    arm_capture(32'h0, 32'h0, 20);
    for (int i = 0; i < 5; i++) begin la_dat_in = stim[i]; tick(); end
    total_cnt++; if (busy !== 1'b1 || triggered !== 1'b1) $display("FAIL abort_pre_state busy=%b trg=%b want 1/1", busy, triggered); else pass_cnt++;
    abort = 1'b1; tick(); abort = 1'b0;
    total_cnt++; if ({busy, done, triggered} !== 3'b000) $display("FAIL abort_post got %b want 000", {busy, done, triggered}); else pass_cnt++;
    for (int i = 0; i < 25; i++) begin la_dat_in = stim[i + 5]; tick(); end
    total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL abort_stays_idle got %b want 00", {busy, done}); else pass_cnt++;
    arm = 1'b1; abort = 1'b1; trig_mask = 32'h0; post_len = 7'd4; tick(); arm = 1'b0; abort = 1'b0;
    tick(); tick();
    total_cnt++; if ({busy, done, triggered} !== 3'b000) $display("FAIL arm_abort_same got %b want 000", {busy, done, triggered}); else pass_cnt++;
  endtask

  task automatic test_read_in_pre();
    fill_ramp();
    arm_capture(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
    for (int i = 0; i < 3; i++) begin la_dat_in = stim[i]; tick(); end
    rd_req = 1'b1; rd_addr = 6'd0; tick(); rd_req = 1'b0;
    total_cnt++; if (rd_valid !== 1'b0 || busy !== 1'b1) $display("FAIL read_in_pre rd_valid=%b busy=%b want 0/1", rd_valid, busy); else pass_cnt++;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_oob_read();
    int da, tot; logic [31:0] d; logic v;
    fill_ramp();
    tot = model_trig(32'hFF, 32'h02) + eff_post(8);
    arm_capture(32'hFF, 32'h02, 8);
    run_samples(-1, da);
    total_cnt++; if (fill_cnt !== 7'(model_fill(tot))) $display("FAIL oob_fill got %0d want %0d", fill_cnt, model_fill(tot)); else pass_cnt++;
    do_read(9, d, v);
    total_cnt++; if (v !== 1'b1 || d !== model_rd(tot, 9)) $display("FAIL oob_read9 got %h want %h", d, model_rd(tot, 9)); else pass_cnt++;
    tick();
    total_cnt++; if (rd_valid !== 1'b0 || rd_data !== model_rd(tot, 9)) $display("FAIL rd_hold v=%b d=%h want 0/%h", rd_valid, rd_data, model_rd(tot, 9)); else pass_cnt++;
    do_read(60, d, v);
    total_cnt++; if (v !== 1'b1 || d !== 32'h0) $display("FAIL oob_read60 got %h v=%b want 0/1", d, v); else pass_cnt++;
  endtask

  task automatic test_rst_mid_post();
    fill_ramp();
    arm_capture(32'h0, 32'h0, 20);
    for (int i = 0; i < 5; i++) begin la_dat_in = stim[i]; tick(); end
    rst = 1'b1; tick();
    total_cnt++; if ({busy, done, triggered, rd_valid} !== 4'b0000) $display("FAIL rst_mid_flags got %b want 0000", {busy, done, triggered, rd_valid}); else pass_cnt++;
    total_cnt++; if (fill_cnt !== 7'd0 || trig_idx !== 6'd0 || rd_data !== 32'h0) $display("FAIL rst_mid_vals fill=%0d tidx=%0d d=%h want 0", fill_cnt, trig_idx, rd_data); else pass_cnt++;
    rst = 1'b0; tick();
  endtask

  task automatic test_random();
    int da, tot, tg, fpos, plen; logic [31:0] m, vv, d; logic v;
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 512; i++) stim[i] = $urandom;
      m    = $urandom & $urandom & 32'h0F0F_0F0F;
      vv   = $urandom;
      fpos = $urandom_range(0, 150);
      stim[fpos] = (stim[fpos] & ~m) | (vv & m);
      plen = $urandom_range(0, 127);
      tg   = model_trig(m, vv);
      tot  = tg + eff_post(plen);
      arm_capture(m, vv, plen);
      run_samples(-1, da);
      total_cnt++; if (da !== tot) $display("FAIL rand%0d_latency got %0d want %0d", it, da, tot); else pass_cnt++;
      total_cnt++; if (fill_cnt !== 7'(model_fill(tot)) || trig_idx !== 6'(model_tidx(tg, tot))) $display("FAIL rand%0d_idx fill=%0d tidx=%0d want %0d/%0d", it, fill_cnt, trig_idx, model_fill(tot), model_tidx(tg, tot)); else pass_cnt++;
      for (int a = 0; a < DEPTH; a++) begin
        do_read(a, d, v);
        total_cnt++; if (v !== 1'b1 || d !== model_rd(tot, a)) $display("FAIL rand%0d_read[%0d] got %h v=%b want %h", it, a, d, v, model_rd(tot, a)); else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trig_mid(-1);
    test_wrap();
    test_post_len_bounds();
    test_trig_mid(10);
    test_abort();
    test_read_in_pre();
    test_oob_read();
    test_rst_mid_post();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
